fdiv_issue_queue: RTL and testbench

Request front-end for the multi-cycle FP32 divider. Accepts divide requests over a valid/ready handshake, buffers them in a small FIFO, and issues them to the divider one at a time, because the divider has no backpressure and holds only one operation. It also captures each result with its request tag and returns it over a valid/ready handshake. It sits between the FPU dispatch logic and the divider.

---
 rtl/fdiv_pkg.sv | 36 +++
 rtl/fdiv_issue_queue_if.sv | 54 +++++
 rtl/fdiv_req_fifo.sv | 55 +++++
 rtl/fdiv_issue_queue.sv | 118 +++++++++++
 tb/tb_fdiv_issue_queue.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fdiv_pkg.sv
// Shared types and constants for the FP32 divider issue front-end.
package fdiv_pkg;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam int REQ_W = 67;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fsm_e;

  typedef struct packed {
    logic [2:0]  rm;
    logic [31:0] dividend;
    logic [31:0] divisor;
  } req_t;

  function automatic logic [4:0] pack_flags(input logic nv, input logic dz,
                                            input logic of, input logic uf,
                                            input logic nx);
    logic [4:0] f;
    f          = '0;
    f[FLAG_NV] = nv;
    f[FLAG_DZ] = dz;
    f[FLAG_OF] = of;
    f[FLAG_UF] = uf;
    f[FLAG_NX] = nx;
    return f;
  endfunction

endpackage

// File: rtl/fdiv_issue_queue_if.sv
// Request, divider-side and result handshakes of the FP32 divider issue queue.
interface fdiv_issue_queue_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_rm;
  logic [31:0]      in_dividend;
  logic [31:0]      in_divisor;
  logic [TAG_W-1:0] in_tag;

  logic             div_valid_in;
  logic [2:0]       div_rm;
  logic [31:0]      div_dividend;
  logic [31:0]      div_divisor;
  logic             div_valid_out;
  logic [31:0]      div_quotient;
  logic             div_nv;
  logic             div_dz;
  logic             div_of;
  logic             div_uf;
  logic             div_nx;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_quotient;
  logic [4:0]       out_flags;
  logic [TAG_W-1:0] out_tag;

  logic             busy;
  logic [CNT_W-1:0] count;

  // Environment side: dispatch, divider model and result consumer.
  modport master (
    output in_valid, in_rm, in_dividend, in_divisor, in_tag,
    output div_valid_out, div_quotient, div_nv, div_dz, div_of, div_uf, div_nx,
    output out_ready,
    input  in_ready, div_valid_in, div_rm, div_dividend, div_divisor,
    input  out_valid, out_quotient, out_flags, out_tag, busy, count
  );

  // Issue queue side.
  modport slave (
    input  in_valid, in_rm, in_dividend, in_divisor, in_tag,
    input  div_valid_out, div_quotient, div_nv, div_dz, div_of, div_uf, div_nx,
    input  out_ready,
    output in_ready, div_valid_in, div_rm, div_dividend, div_divisor,
    output out_valid, out_quotient, out_flags, out_tag, busy, count
  );

endinterface

// File: rtl/fdiv_req_fifo.sv
// Synchronous request FIFO with occupancy count; storage is not reset.
module fdiv_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 71
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign count   = count_q;

endmodule

// File: rtl/fdiv_issue_queue.sv
// Buffers FP32 divide requests and issues them one at a time to a divider
// without backpressure, then holds each tagged result until consumed.
module fdiv_issue_queue
  import fdiv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  fdiv_issue_queue_if.slave bus
);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int WORD_W = REQ_W + TAG_W;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fdiv_issue_queue: DEPTH must be a power of two and at least 2");
  end

  req_t              in_req;
  req_t              head_req;
  logic [TAG_W-1:0]  head_tag;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] rd_word;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;

  fsm_e              state_q;
  fsm_e              state_d;
  logic              issue;
  logic              complete;

  logic              out_valid_q;
  logic [31:0]       quot_q;
  logic [4:0]        flags_q;
  logic [TAG_W-1:0]  tag_q;
  logic [TAG_W-1:0]  inflight_tag_q;

  assign in_req  = '{rm: bus.in_rm, dividend: bus.in_dividend, divisor: bus.in_divisor};
  assign wr_word = {in_req, bus.in_tag};
  assign {head_req, head_tag} = rd_word;
  assign push    = bus.in_valid && !fifo_full;

  fdiv_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (wr_word),
    .pop     (issue),
    .rd_data (rd_word),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Issue only when the result slot is empty or being drained this cycle, so
  // a completion can always land in it.
  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && (!out_valid_q || bus.out_ready)) begin
          issue   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.div_valid_out) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (complete)
        out_valid_q <= 1'b1;
      else if (out_valid_q && bus.out_ready)
        out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) inflight_tag_q <= head_tag;
    if (complete) begin
      quot_q  <= bus.div_quotient;
      flags_q <= pack_flags(bus.div_nv, bus.div_dz, bus.div_of, bus.div_uf, bus.div_nx);
      tag_q   <= inflight_tag_q;
    end
  end

  assign bus.in_ready     = !fifo_full;
  assign bus.count        = fifo_count;
  assign bus.div_valid_in = issue;
  assign bus.div_rm       = head_req.rm;
  assign bus.div_dividend = head_req.dividend;
  assign bus.div_divisor  = head_req.divisor;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_quotient = quot_q;
  assign bus.out_flags    = flags_q;
  assign bus.out_tag      = tag_q;
  assign bus.busy         = !fifo_empty || (state_q == WAIT) || out_valid_q;

endmodule

// File: tb/tb_fdiv_issue_queue.sv
// Directed bench for fdiv_issue_queue with a queue-level reference model and a divider stand-in.
module tb_fdiv_issue_queue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  typedef struct {
    logic [2:0]       rm;
    logic [31:0]      dvd;
    logic [31:0]      dvs;
    logic [TAG_W-1:0] tag;
  } rec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fdiv_issue_queue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) ifc ();

  fdiv_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in divider arithmetic: exact for power-of-two divisors with an empty mantissa.
  function automatic logic [31:0] fake_div(input logic [31:0] a, input logic [31:0] b);
    return a - b + 32'h3F800000;
  endfunction

  function automatic logic [4:0] fake_flags(input logic [2:0] rm, input logic [31:0] a,
                                            input logic [31:0] b);
    return {(b[30:0] == 0) && (a[30:0] == 0), (b[30:0] == 0) && (a[30:0] != 0),
            rm == 3'd7, a[31] ^ b[31], a[0] ^ b[0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  rec_t mq[$];
  rec_t cur;
  bit   inflight;
  bit   res_valid;
  logic [31:0]      res_q;
  logic [4:0]       res_f;
  logic [TAG_W-1:0] res_tag;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      inflight  = 0;
      res_valid = 0;
    end else begin
      bit   iss, acc, cmp;
      rec_t nr;
      iss = !inflight && mq.size() > 0 && (!res_valid || ifc.out_ready);
      acc = ifc.in_valid && mq.size() != DEPTH;
      cmp = inflight && ifc.div_valid_out;
      nr.rm = ifc.in_rm; nr.dvd = ifc.in_dividend; nr.dvs = ifc.in_divisor; nr.tag = ifc.in_tag;
      if (cmp) begin
        res_valid = 1;
        res_q     = fake_div(cur.dvd, cur.dvs);
        res_f     = fake_flags(cur.rm, cur.dvd, cur.dvs);
        res_tag   = cur.tag;
        inflight  = 0;
      end else if (res_valid && ifc.out_ready) begin
        res_valid = 0;
      end
      if (iss) begin
        cur      = mq.pop_front();
        inflight = 1;
      end
      if (acc) mq.push_back(nr);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    int sz;
    bit exp_iss;
    sz      = mq.size();
    exp_iss = !rst && !inflight && sz > 0 && (!res_valid || ifc.out_ready);
    chk("count", ifc.count, sz);
    chk("in_ready", ifc.in_ready, sz != DEPTH);
    chk("div_valid_in", ifc.div_valid_in, exp_iss);
    if (exp_iss) begin
      chk("div_rm", ifc.div_rm, mq[0].rm);
      chk("div_dividend", ifc.div_dividend, mq[0].dvd);
      chk("div_divisor", ifc.div_divisor, mq[0].dvs);
    end
    chk("out_valid", ifc.out_valid, res_valid);
    if (res_valid) begin
      chk("out_quotient", ifc.out_quotient, res_q);
      chk("out_flags", ifc.out_flags, res_f);
      chk("out_tag", ifc.out_tag, res_tag);
    end
    chk("busy", ifc.busy, sz > 0 || inflight || res_valid);
  end

  // ---------------- divider stand-in ----------------
  int          div_lat;
  bit          spur;
  bit          iss_s;
  bit          pending;
  int          cnt;
  logic [2:0]  op_rm, p_rm;
  logic [31:0] op_dvd, op_dvs, p_dvd, p_dvs;

  always @(negedge clk) begin
    iss_s  = ifc.div_valid_in;
    op_rm  = ifc.div_rm;
    op_dvd = ifc.div_dividend;
    op_dvs = ifc.div_divisor;
  end

  always @(posedge clk) begin
    bit pulse;
    logic [4:0] f;
    #1;
    pulse = 0;
    if (rst) begin
      pending = 0;
    end else begin
      if (iss_s) begin
        pending = 1; cnt = div_lat; p_rm = op_rm; p_dvd = op_dvd; p_dvs = op_dvs;
      end
      if (pending) begin
        cnt--;
        if (cnt == 0) begin pulse = 1; pending = 0; end
      end
    end
    ifc.div_valid_out = pulse | spur;
    if (pulse) begin
      f = fake_flags(p_rm, p_dvd, p_dvs);
      ifc.div_quotient = fake_div(p_dvd, p_dvs);
      {ifc.div_nv, ifc.div_dz, ifc.div_of, ifc.div_uf, ifc.div_nx} = f;
    end else begin
      ifc.div_quotient = 32'hDEADBEEF;
      {ifc.div_nv, ifc.div_dz, ifc.div_of, ifc.div_uf, ifc.div_nx} = 5'h1F;
    end
  end

  // Result collector.
  logic [TAG_W-1:0] got[$];
  always @(negedge clk) begin
    if (!rst && ifc.out_valid && ifc.out_ready) got.push_back(ifc.out_tag);
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push_req(input logic [2:0] rm, input logic [31:0] dvd,
                          input logic [31:0] dvs, input logic [TAG_W-1:0] tag);
    int k;
    ifc.in_valid = 1; ifc.in_rm = rm; ifc.in_dividend = dvd; ifc.in_divisor = dvs;
    ifc.in_tag = tag;
    k = 0;
    while (!ifc.in_ready && k < 300) begin cyc(); k++; end
    if (k == 300) chk("push_timeout", 0, 1);
    cyc();
    ifc.in_valid = 0;
  endtask

  task automatic wait_got(input int n, input string name);
    int k;
    k = 0;
    while (got.size() < n && k < 1000) begin cyc(); k++; end
    chk(name, got.size(), n);
  endtask

  task automatic wait_div_out(input string name);
    int k;
    k = 0;
    while (!ifc.div_valid_out && k < 100) begin cyc(); k++; end
    chk(name, ifc.div_valid_out, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "bench timed out");
  end

  initial begin
    checks = 0; errors = 0;
    rst = 1; div_lat = 3; spur = 0;
    ifc.in_valid = 0; ifc.in_rm = 0; ifc.in_dividend = 0; ifc.in_divisor = 0; ifc.in_tag = 0;
    ifc.out_ready = 1; ifc.div_valid_out = 0; ifc.div_quotient = 0;
    {ifc.div_nv, ifc.div_dz, ifc.div_of, ifc.div_uf, ifc.div_nx} = 0;
    cyc(); cyc();
    chk("rst_count", ifc.count, 0);
    chk("rst_in_ready", ifc.in_ready, 1);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_div_valid_in", ifc.div_valid_in, 0);
    rst = 0;
    cyc();

    // Single op: pi / 2.
    got.delete();
    push_req(3'd0, 32'h40490FDB, 32'h40000000, 4'd3);
    chk("single_issue_t1", ifc.div_valid_in, 1);
    chk("single_issue_dvd", ifc.div_dividend, 32'h40490FDB);
    cyc();
    chk("single_one_pulse", ifc.div_valid_in, 0);
    wait_div_out("single_done");
    chk("single_not_yet", ifc.out_valid, 0);
    cyc();
    chk("single_out_valid", ifc.out_valid, 1);
    chk("single_quot", ifc.out_quotient, 32'h3FC90FDB);
    chk("single_flags", ifc.out_flags, 5'h01);
    chk("single_tag", ifc.out_tag, 3);
    wait_got(1, "single_got");
    cyc(); cyc();

    // Fill while the divider stalls, then push once more while full.
    got.delete();
    div_lat = 30;
    for (int i = 0; i < 5; i++)
      push_req(3'(i), 32'h3F800000 + 32'h00100000 * i, 32'h3F000000 + i, 4'(i));
    chk("fill_count4", ifc.count, 4);
    chk("fill_not_ready", ifc.in_ready, 0);
    push_req(3'd7, 32'hC0A00000, 32'h00000000, 4'd5);
    chk("full_push_count", ifc.count, 4);
    wait_got(6, "fill_got");
    for (int i = 0; i < 6; i++) chk("fill_tag_order", (i < got.size()) ? got[i] : 4'hF, i);
    cyc();

    // Backpressure on the result slot.
    got.delete();
    div_lat = 2;
    push_req(3'd1, 32'h41200000, 32'h40A00000, 4'd8);
    push_req(3'd2, 32'h42C80000, 32'h41200000, 4'd9);
    wait_div_out("bp_first_done");
    ifc.out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_no_issue", ifc.div_valid_in, 0);
      chk("bp_held", ifc.out_valid, 1);
    end
    chk("bp_held_tag", ifc.out_tag, 8);
    ifc.out_ready = 1;
    #1;
    chk("bp_issue_same_cycle", ifc.div_valid_in, 1);
    wait_got(2, "bp_got");
    chk("bp_tag0", got[0], 8);
    chk("bp_tag1", got[1], 9);
    cyc(); cyc();

    // Spurious completion while idle.
    spur = 1;
    cyc();
    spur = 0;
    cyc(); cyc();
    chk("spur_out_valid", ifc.out_valid, 0);
    chk("spur_count", ifc.count, 0);

    // Reset with two queued and one in flight.
    div_lat = 40;
    push_req(3'd0, 32'h3F800000, 32'h40000000, 4'd1);
    push_req(3'd0, 32'h40000000, 32'h40000000, 4'd2);
    push_req(3'd0, 32'h40400000, 32'h40000000, 4'd3);
    chk("pre_rst_count", ifc.count, 2);
    chk("pre_rst_busy", ifc.busy, 1);
    #1;
    rst = 1;
    #1;
    chk("rst_mid_count", ifc.count, 0);
    chk("rst_mid_out_valid", ifc.out_valid, 0);
    chk("rst_mid_div_valid_in", ifc.div_valid_in, 0);
    chk("rst_mid_in_ready", ifc.in_ready, 1);
    chk("rst_mid_busy", ifc.busy, 0);
    cyc(); cyc();
    rst = 0;
    repeat (5) cyc();
    chk("post_rst_idle", ifc.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
